image_pattern_gen: RTL and testbench
====================================

// Module: image_pattern_gen
// PURPOSE
//  Parametrised streaming test-pattern source for the video card datapath; successor to the fixed 24-bit image_test source.
//  Emits one frame of H_ACTIVE x V_ACTIVE packed RGB pixels in raster order over a valid/ready stream, with SOF/EOL markers.
//  Supports four run-time patterns and a frame counter; feeds the frame buffer writer or scan-out path during bring-up and verification.
// PARAMETERS
//  H_ACTIVE    640  pixels per line (>=2)
//  V_ACTIVE    480  lines per frame (>=1)
//  PIX_W       24   packed pixel width {R,G,B}, R in MSBs; multiple of 3; C = PIX_W/3 bits per channel
//  CHECK_LOG2  3    checkerboard square size = 2**CHECK_LOG2 pixels
// PORTS
//  clk         in   1        single clock, all logic rising-edge
//  rst_n       in   1        asynchronous active-low reset
//  enable      in   1        run request; sampled at frame boundaries
//  mode        in   2        0 solid, 1 colour bars, 2 checkerboard, 3 gradient
//  solid_rgb   in   PIX_W    colour for mode 0
//  m_valid     out  1        pixel beat valid
//  m_ready     in   1        downstream accept
//  m_data      out  PIX_W    pixel
//  m_sof       out  1        high with pixel (0,0)
//  m_eol       out  1        high with pixel x=H_ACTIVE-1
//  frame_cnt   out  16       completed frames, wraps 0xFFFF->0
// BEHAVIOUR
//  Reset (async assert, sync release): m_valid=0, m_data=0, m_sof=0, m_eol=0, frame_cnt=0, x=y=0, state IDLE.
//  States: IDLE -> RUN when enable=1 at a clk edge; on that same edge m_valid=1 and pixel (0,0) with m_sof=1 is registered (1-cycle latency).
//  RUN: beat transfers when m_valid && m_ready; x,y advance only on transfer. All outputs registered.
//  Stall: while m_valid && !m_ready, m_data/m_sof/m_eol held stable; m_valid never drops mid-frame.
//  x wraps H_ACTIVE-1 -> 0 with y+1; after (H_ACTIVE-1,V_ACTIVE-1) transfers: frame_cnt+1, x=y=0.
//  Frame end with enable=1: next edge presents (0,0) of the next frame (no bubble). With enable=0: -> IDLE, m_valid=0 next edge.
//  enable deassert mid-frame: current frame completes; no truncated frames.
//  mode and solid_rgb latched into shadow regs at each frame start (IDLE->RUN or wrap); mid-frame changes ignored.
//  Patterns (ALL1 = all C bits one):
//   0 solid: solid_rgb.
//   1 bars: bar = (x*8)/H_ACTIVE (integer); 0..7 = white,yellow,cyan,green,magenta,red,blue,black; channels ALL1 or 0.
//   2 checker: ((x>>CHECK_LOG2) ^ (y>>CHECK_LOG2)) bit0 = 0 -> white, 1 -> black.
//   3 gradient: R=x[C-1:0], G=y[C-1:0], B=frame_cnt[C-1:0] (truncation; frame_cnt value at frame start).
//  Counters sized $clog2(H_ACTIVE), $clog2(V_ACTIVE); bar multiply done at x width + 3 bits, no overflow.
//  Reset mid-frame: immediate abort, m_valid low asynchronously; restart begins at (0,0), frame_cnt=0.
// STRUCTURE
//  video_pkg: mode encoding localparams (MODE_SOLID/BARS/CHECK/GRAD), 8-entry colour-bar RGB table as 3-bit {R,G,B} masks, pack_rgb function.
//  Sub-module image_pattern_pixel: combinational (x,y,mode,solid,frame) -> PIX_W pixel; top holds FSM, counters, shadow regs, output regs.
// TESTING
//  Params H=8,V=2,PIX_W=24; mode 1, enable=1, m_ready=1 -> 16 beats, line 0 = FFFFFF,FFFF00,00FFFF,00FF00,FF00FF,FF0000,0000FF,000000; m_sof beat 0, m_eol beats 7,15; frame_cnt=1.
//  Mode 2, CHECK_LOG2=1, H=8,V=4 -> row0 = W,W,K,K,W,W,K,K; row2 inverted; rows 1,3 equal rows 0,2.
//  Mode 3, two back-to-back frames -> beat (x=5,y=1) of frame 0 = 050100, of frame 1 = 050101; no idle cycle between frames.
//  m_ready random 50% -> m_data/m_sof/m_eol stable while stalled; beat sequence identical to m_ready=1 run.
//  mode 0 -> 2 changed and enable dropped mid-frame -> frame finishes in mode 0, m_valid=0 next cycle after last beat; mode 2 only on next enable.
//  rst_n pulsed low at beat 5 -> m_valid=0 immediately, frame_cnt=0; after release, first beat is (0,0) with m_sof=1.

Source files
------------

// File: rtl/video_pkg.sv
// Shared definitions for the streaming test-pattern source: mode encoding,
// FSM state type, colour-bar table and a helper that expands a 3-bit
// {R,G,B} on/off mask into a packed pixel.
package video_pkg;

    localparam logic [1:0] MODE_SOLID = 2'd0;
    localparam logic [1:0] MODE_BARS  = 2'd1;
    localparam logic [1:0] MODE_CHECK = 2'd2;
    localparam logic [1:0] MODE_GRAD  = 2'd3;

    // Widest pixel pack_rgb can build; callers truncate to their PIX_W.
    localparam int PIX_MAX = 96;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } gen_state_e;

    // Colour bars indexed by bar number 0..7, each entry a {R,G,B} mask:
    // white, yellow, cyan, green, magenta, red, blue, black.
    localparam logic [7:0][2:0] BAR_RGB = {
        3'b000, 3'b001, 3'b100, 3'b101, 3'b010, 3'b011, 3'b110, 3'b111
    };

    // Expand a {R,G,B} mask into channels of c bits each, R in the MSBs.
    function automatic logic [PIX_MAX-1:0] pack_rgb(input logic [2:0] mask,
                                                     input int unsigned c);
        logic [PIX_MAX-1:0] ch;
        ch = (PIX_MAX'(1) << c) - PIX_MAX'(1);
        return ((({PIX_MAX{mask[2]}} & ch) << (2 * c)) |
                (({PIX_MAX{mask[1]}} & ch) << c) |
                 ({PIX_MAX{mask[0]}} & ch));
    endfunction

endpackage

// File: rtl/image_pattern_pixel.sv
// Combinational pixel generator: maps a raster position plus the
// frame-start shadow values (mode, solid colour, frame number) to one
// packed RGB pixel.
module image_pattern_pixel
    import video_pkg::*;
#(
    parameter int H_ACTIVE   = 640,
    parameter int V_ACTIVE   = 480,
    parameter int PIX_W      = 24,
    parameter int CHECK_LOG2 = 3,
    parameter int XW         = 10,
    parameter int YW         = 9
) (
    input  logic [XW-1:0]    x,
    input  logic [YW-1:0]    y,
    input  logic [1:0]       mode,
    input  logic [PIX_W-1:0] solid,
    input  logic [15:0]      frame,
    output logic [PIX_W-1:0] pix
);

    localparam int C = PIX_W / 3;

    logic [XW+2:0] bar_prod;
    logic [2:0]    bar;
    logic          chk_par;

    // Select the pattern; the bar product is carried at x width + 3 bits
    // so x*8 cannot overflow before the divide.
    always_comb begin
        bar_prod = {x, 3'b000};
        bar      = 3'(bar_prod / (XW+3)'(H_ACTIVE));
        chk_par  = 1'(x >> CHECK_LOG2) ^ 1'(y >> CHECK_LOG2);
        case (mode)
            MODE_SOLID: pix = solid;
            MODE_BARS:  pix = PIX_W'(pack_rgb(BAR_RGB[bar], C));
            MODE_CHECK: pix = PIX_W'(pack_rgb(chk_par ? 3'b000 : 3'b111, C));
            default:    pix = {C'(x), C'(y), C'(frame)};
        endcase
    end

endmodule

// File: rtl/image_pattern_gen.sv
// Streaming test-pattern source: emits H_ACTIVE x V_ACTIVE frames in raster
// order over valid/ready with SOF/EOL markers. Mode and solid colour are
// captured at every frame start so a frame never mixes patterns.
module image_pattern_gen
    import video_pkg::*;
#(
    parameter int H_ACTIVE   = 640,
    parameter int V_ACTIVE   = 480,
    parameter int PIX_W      = 24,
    parameter int CHECK_LOG2 = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic [1:0]       mode,
    input  logic [PIX_W-1:0] solid_rgb,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [PIX_W-1:0] m_data,
    output logic             m_sof,
    output logic             m_eol,
    output logic [15:0]      frame_cnt
);

    localparam int XW = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;
    localparam int YW = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1;
    localparam logic [XW-1:0] X_LAST = XW'(H_ACTIVE - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(V_ACTIVE - 1);

    gen_state_e       state, state_nxt;
    logic [XW-1:0]    x, x_adv, px;
    logic [YW-1:0]    y, y_adv, py;
    logic [1:0]       mode_sh, mode_n;
    logic [PIX_W-1:0] solid_sh, solid_n, pix;
    logic [15:0]      frm_sh, frm_n, cnt_n;
    logic             fire, frame_last, frame_start, go_idle, load;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    // Next state: start on enable, fall back to idle only at a frame end.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (enable)  state_nxt = ST_RUN;
            ST_RUN:  if (go_idle) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Beat decode and next-pixel selection. (x,y) is the position of the
    // pixel currently on the bus; (px,py) is the one to register next.
    always_comb begin
        fire        = m_valid & m_ready;
        frame_last  = fire && (x == X_LAST) && (y == Y_LAST);
        frame_start = enable && ((state == ST_IDLE) || frame_last);
        go_idle     = frame_last && !enable;
        load        = frame_start || fire;
        x_adv       = (x == X_LAST) ? '0 : x + XW'(1);
        y_adv       = (x == X_LAST) ? ((y == Y_LAST) ? '0 : y + YW'(1)) : y;
        px          = fire ? x_adv : x;
        py          = fire ? y_adv : y;
        cnt_n       = frame_last ? frame_cnt + 16'd1 : frame_cnt;
        mode_n      = frame_start ? mode      : mode_sh;
        solid_n     = frame_start ? solid_rgb : solid_sh;
        frm_n       = frame_start ? cnt_n     : frm_sh;
    end

    image_pattern_pixel #(
        .H_ACTIVE  (H_ACTIVE),
        .V_ACTIVE  (V_ACTIVE),
        .PIX_W     (PIX_W),
        .CHECK_LOG2(CHECK_LOG2),
        .XW        (XW),
        .YW        (YW)
    ) u_pixel (
        .x    (px),
        .y    (py),
        .mode (mode_n),
        .solid(solid_n),
        .frame(frm_n),
        .pix  (pix)
    );

    // Counters, shadow registers and output registers; outputs only move
    // on a frame start or an accepted beat, so a stall holds them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x         <= '0;
            y         <= '0;
            frame_cnt <= '0;
            mode_sh   <= MODE_SOLID;
            solid_sh  <= '0;
            frm_sh    <= '0;
            m_valid   <= 1'b0;
            m_data    <= '0;
            m_sof     <= 1'b0;
            m_eol     <= 1'b0;
        end else begin
            if (fire) begin
                x <= x_adv;
                y <= y_adv;
            end
            if (frame_last) frame_cnt <= cnt_n;
            if (frame_start) begin
                mode_sh  <= mode;
                solid_sh <= solid_rgb;
                frm_sh   <= cnt_n;
            end
            if (frame_start)  m_valid <= 1'b1;
            else if (go_idle) m_valid <= 1'b0;
            if (go_idle) begin
                m_sof <= 1'b0;
                m_eol <= 1'b0;
            end else if (load) begin
                m_data <= pix;
                m_sof  <= (px == '0) && (py == '0);
                m_eol  <= (px == X_LAST);
            end
        end
    end

endmodule

// File: tb/tb_image_pattern_gen.sv
// Bench for image_pattern_gen (H=8, V=4, 24-bit, 2x2 checker squares).
// A beat-index reference model predicts every output on each falling edge;
// directed runs add hand-computed literal expectations.
module tb_image_pattern_gen;

    localparam int H = 8, V = 4, PW = 24, CL2 = 1, N = H * V;

    localparam logic [23:0] BARS_L0 [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                                            24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};
    localparam logic [23:0] CHK_R0 [8]  = '{24'hFFFFFF, 24'hFFFFFF, 24'h000000, 24'h000000,
                                            24'hFFFFFF, 24'hFFFFFF, 24'h000000, 24'h000000};
    localparam logic [23:0] CHK_R2 [8]  = '{24'h000000, 24'h000000, 24'hFFFFFF, 24'hFFFFFF,
                                            24'h000000, 24'h000000, 24'hFFFFFF, 24'hFFFFFF};

    logic          clk = 1'b0;
    logic          rst_n, enable, m_ready, m_valid, m_sof, m_eol;
    logic [1:0]    mode;
    logic [PW-1:0] solid_rgb, m_data;
    logic [15:0]   frame_cnt;

    int checks = 0, failures = 0, cyc = 0;

    logic [23:0] cap_d[$];
    logic        cap_sof[$], cap_eol[$];
    int          cap_cyc[$];
    logic [23:0] ref_d[$];

    always #5 clk = ~clk;

    image_pattern_gen #(.H_ACTIVE(H), .V_ACTIVE(V), .PIX_W(PW), .CHECK_LOG2(CL2)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .mode(mode), .solid_rgb(solid_rgb),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_sof(m_sof),
        .m_eol(m_eol), .frame_cnt(frame_cnt)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Pattern rules straight from the pattern definitions.
    function automatic logic [23:0] exp_pixel(input int x, input int y, input int md,
                                              input logic [23:0] sol, input int frm);
        case (md)
            0: return sol;
            1: case ((x * 8) / H)
                   0: return 24'hFFFFFF;
                   1: return 24'hFFFF00;
                   2: return 24'h00FFFF;
                   3: return 24'h00FF00;
                   4: return 24'hFF00FF;
                   5: return 24'hFF0000;
                   6: return 24'h0000FF;
                   default: return 24'h000000;
               endcase
            2: return ((((x / 2) + (y / 2)) % 2) == 0) ? 24'hFFFFFF : 24'h000000;
            default: return {8'(x), 8'(y), 8'(frm)};
        endcase
    endfunction

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Record every accepted beat.
    initial forever begin
        @(negedge clk);
        if (rst_n === 1'b1 && m_valid === 1'b1 && m_ready === 1'b1) begin
            cap_d.push_back(m_data);
            cap_sof.push_back(m_sof);
            cap_eol.push_back(m_eol);
            cap_cyc.push_back(cyc);
        end
    end

    // Reference model: beat index k within the frame, frames completed,
    // and the mode/colour/frame number captured at frame start.
    initial begin
        bit          mv = 0, pv = 0, pr = 0, ps = 0, pe = 0;
        int          k = 0, mfr = 0, sh_mode = 0, sh_frm = 0;
        logic [23:0] sh_sol = '0, pd = '0;
        forever begin
            @(negedge clk);
            if (rst_n !== 1'b1) begin
                chk("rst_valid", 32'(m_valid), 0);
                chk("rst_data", 32'(m_data), 0);
                chk("rst_sof_eol", {30'd0, m_sof, m_eol}, 0);
                chk("rst_frame_cnt", 32'(frame_cnt), 0);
                mv = 0; k = 0; mfr = 0; pv = 0;
            end else begin
                chk("valid", 32'(m_valid), 32'(mv));
                chk("frame_cnt", 32'(frame_cnt), 32'(mfr & 16'hFFFF));
                if (mv) begin
                    chk("data", 32'(m_data), 32'(exp_pixel(k % H, k / H, sh_mode, sh_sol, sh_frm)));
                    chk("sof", 32'(m_sof), 32'(k == 0));
                    chk("eol", 32'(m_eol), 32'((k % H) == H - 1));
                end
                if (pv && !pr) begin
                    chk("stall_data", 32'(m_data), 32'(pd));
                    chk("stall_marks", {30'd0, m_sof, m_eol}, {30'd0, ps, pe});
                end
                pv = m_valid; pr = m_ready; pd = m_data; ps = m_sof; pe = m_eol;
                if (mv && m_ready) begin
                    k++;
                    if (k == N) begin
                        k = 0;
                        mfr++;
                        if (enable) begin
                            sh_mode = int'(mode); sh_sol = solid_rgb; sh_frm = mfr;
                        end else begin
                            mv = 0;
                        end
                    end
                end else if (!mv && enable) begin
                    mv = 1; k = 0;
                    sh_mode = int'(mode); sh_sol = solid_rgb; sh_frm = mfr;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_cap();
        cap_d.delete(); cap_sof.delete(); cap_eol.delete(); cap_cyc.delete();
    endtask

    task automatic wait_beats(input int n, input int budget);
        int c = 0;
        while (cap_d.size() < n && c < budget) begin
            tick();
            c++;
        end
        chk("wait_beats", 32'(cap_d.size() >= n), 1);
    endtask

    task automatic wait_idle(input int budget);
        int c = 0;
        while (m_valid === 1'b1 && c < budget) begin
            tick();
            c++;
        end
        chk("wait_idle", 32'(m_valid), 0);
    endtask

    initial begin
        int bad;
        rst_n = 1'b0; enable = 1'b0; mode = 2'd0; solid_rgb = '0; m_ready = 1'b1;
        repeat (3) tick();
        chk("reset_valid_lit", 32'(m_valid), 0);
        chk("reset_frame_lit", 32'(frame_cnt), 0);
        rst_n = 1'b1;
        tick();

        // Gradient, two back-to-back frames.
        clear_cap();
        mode = 2'd3; enable = 1'b1;
        wait_beats(N + 1, 200);
        enable = 1'b0;
        wait_beats(2 * N, 200);
        wait_idle(20);
        chk("grad_f0_x5y1", 32'(cap_d[H + 5]), 32'h050100);
        chk("grad_f1_x5y1", 32'(cap_d[N + H + 5]), 32'h050101);
        chk("grad_no_bubble", 32'(cap_cyc[N] - cap_cyc[N - 1]), 1);
        chk("grad_f1_sof", 32'(cap_sof[N]), 1);
        chk("grad_frame_cnt", 32'(frame_cnt), 2);

        // Colour bars, single frame.
        clear_cap();
        mode = 2'd1; enable = 1'b1;
        tick();
        enable = 1'b0;
        wait_beats(N, 200);
        wait_idle(20);
        for (int i = 0; i < H; i++) chk("bars_line0", 32'(cap_d[i]), 32'(BARS_L0[i]));
        chk("bars_sof0", 32'(cap_sof[0]), 1);
        chk("bars_sof1", 32'(cap_sof[1]), 0);
        chk("bars_eol6", 32'(cap_eol[6]), 0);
        chk("bars_eol7", 32'(cap_eol[7]), 1);
        chk("bars_eol15", 32'(cap_eol[15]), 1);
        chk("bars_frame_cnt", 32'(frame_cnt), 3);
        ref_d = cap_d;

        // Checkerboard with 2x2 squares.
        clear_cap();
        mode = 2'd2; enable = 1'b1;
        tick();
        enable = 1'b0;
        wait_beats(N, 200);
        wait_idle(20);
        for (int i = 0; i < H; i++) begin
            chk("chk_row0", 32'(cap_d[i]), 32'(CHK_R0[i]));
            chk("chk_row1", 32'(cap_d[H + i]), 32'(CHK_R0[i]));
            chk("chk_row2", 32'(cap_d[2 * H + i]), 32'(CHK_R2[i]));
            chk("chk_row3", 32'(cap_d[3 * H + i]), 32'(CHK_R2[i]));
        end

        // Colour bars again under random backpressure.
        clear_cap();
        mode = 2'd1; enable = 1'b1;
        tick();
        enable = 1'b0;
        for (int c = 0; c < 1000 && cap_d.size() < N; c++) begin
            m_ready = 1'($urandom_range(0, 1));
            tick();
        end
        m_ready = 1'b1;
        wait_beats(N, 50);
        wait_idle(20);
        bad = 0;
        for (int i = 0; i < N; i++) if (cap_d[i] !== ref_d[i]) bad++;
        chk("stall_sequence", 32'(bad), 0);

        // Mode change and enable drop mid-frame.
        clear_cap();
        mode = 2'd0; solid_rgb = 24'h123456; enable = 1'b1;
        wait_beats(3, 50);
        mode = 2'd2; solid_rgb = 24'hABCDEF; enable = 1'b0;
        wait_beats(N, 200);
        wait_idle(20);
        bad = 0;
        for (int i = 0; i < N; i++) if (cap_d[i] !== 24'h123456) bad++;
        chk("mode_hold_solid", 32'(bad), 0);
        chk("mode_hold_count", 32'(cap_d.size()), 32'(N));
        clear_cap();
        enable = 1'b1;
        tick();
        enable = 1'b0;
        wait_beats(N, 200);
        wait_idle(20);
        chk("mode_next_px0", 32'(cap_d[0]), 32'hFFFFFF);
        chk("mode_next_px2", 32'(cap_d[2]), 32'h000000);

        // Reset in the middle of a frame.
        clear_cap();
        mode = 2'd1; enable = 1'b1;
        wait_beats(5, 50);
        rst_n = 1'b0;
        #1;
        chk("abort_valid", 32'(m_valid), 0);
        chk("abort_frame_cnt", 32'(frame_cnt), 0);
        tick();
        tick();
        clear_cap();
        rst_n = 1'b1;
        wait_beats(1, 20);
        enable = 1'b0;
        chk("restart_px0", 32'(cap_d[0]), 32'hFFFFFF);
        chk("restart_sof", 32'(cap_sof[0]), 1);
        wait_beats(N, 200);
        wait_idle(20);
        chk("restart_frame_cnt", 32'(frame_cnt), 1);

        repeat (2) tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
